// File: rtl/bitwise_pipe_alu.sv
// Two-stage valid/ready bitwise ALU: result two cycles after accept, one op per cycle, a stall holds both stages.
// Defining BITWISE_PIPE_ALU_REDUCE_EN adds registered AND/OR/XOR reductions of the result.
module bitwise_pipe_alu #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [2:0]       out_op,
    output logic             out_err,
    output logic [CNT_W-1:0] op_count
`ifdef BITWISE_PIPE_ALU_REDUCE_EN
    ,
    output logic             out_red_and,
    output logic             out_red_or,
    output logic             out_red_xor
`endif
);

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NOT  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_XNOR = 3'd6;

    logic             s1_v_q, s1_v_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [2:0]       s1_op_q, s1_op_d;

    logic             s2_v_q, s2_v_d;
    logic [WIDTH-1:0] s2_res_q, s2_res_d;
    logic [2:0]       s2_op_q, s2_op_d;
    logic             s2_err_q, s2_err_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             in_fire;
    logic             out_fire;
    logic             s2_load;
    logic [WIDTH-1:0] alu_res;
    logic             alu_err;

    assign s2_load  = s1_v_q && (!s2_v_q || out_ready);
    assign out_fire = s2_v_q && out_ready;
    // S1 frees up in the same cycle its contents move into S2.
    assign in_ready = !s1_v_q || !s2_v_q || out_ready;
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (s1_op_q)
            OP_AND:  alu_res = s1_a_q & s1_b_q;
            OP_OR:   alu_res = s1_a_q | s1_b_q;
            OP_NOT:  alu_res = ~s1_a_q;
            OP_NAND: alu_res = ~(s1_a_q & s1_b_q);
            OP_NOR:  alu_res = ~(s1_a_q | s1_b_q);
            OP_XOR:  alu_res = s1_a_q ^ s1_b_q;
            OP_XNOR: alu_res = ~(s1_a_q ^ s1_b_q);
            default: alu_err = 1'b1;
        endcase
    end

    always_comb begin
        s1_v_d   = in_fire | (s1_v_q & ~s2_load);
        s1_a_d   = in_fire ? in_a  : s1_a_q;
        s1_b_d   = in_fire ? in_b  : s1_b_q;
        s1_op_d  = in_fire ? in_op : s1_op_q;

        s2_v_d   = s2_load | (s2_v_q & ~out_ready);
        s2_res_d = s2_load ? alu_res : s2_res_q;
        s2_op_d  = s2_load ? s1_op_q : s2_op_q;
        s2_err_d = s2_load ? alu_err : s2_err_q;

        cnt_d    = out_fire ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q   <= 1'b0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s1_op_q  <= '0;
            s2_v_q   <= 1'b0;
            s2_res_q <= '0;
            s2_op_q  <= '0;
            s2_err_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_v_q   <= s1_v_d;
            s1_a_q   <= s1_a_d;
            s1_b_q   <= s1_b_d;
            s1_op_q  <= s1_op_d;
            s2_v_q   <= s2_v_d;
            s2_res_q <= s2_res_d;
            s2_op_q  <= s2_op_d;
            s2_err_q <= s2_err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_valid  = s2_v_q;
    assign out_result = s2_res_q;
    assign out_op     = s2_op_q;
    assign out_err    = s2_err_q;
    assign op_count   = cnt_q;

`ifdef BITWISE_PIPE_ALU_REDUCE_EN
    logic red_and_q, red_and_d;
    logic red_or_q,  red_or_d;
    logic red_xor_q, red_xor_d;

    always_comb begin
        red_and_d = s2_load ? (&alu_res) : red_and_q;
        red_or_d  = s2_load ? (|alu_res) : red_or_q;
        red_xor_d = s2_load ? (^alu_res) : red_xor_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            red_and_q <= 1'b0;
            red_or_q  <= 1'b0;
            red_xor_q <= 1'b0;
        end else begin
            red_and_q <= red_and_d;
            red_or_q  <= red_or_d;
            red_xor_q <= red_xor_d;
        end
    end

    assign out_red_and = red_and_q;
    assign out_red_or  = red_or_q;
    assign out_red_xor = red_xor_q;
`endif

endmodule

// File: tb/tb_bitwise_pipe_alu.sv
// Directed and scoreboarded checks for bitwise_pipe_alu; a second CNT_W=4 instance covers counter wrap.
module tb_bitwise_pipe_alu;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_result;
    logic [2:0]  out_op;
    logic        out_err;
    logic [15:0] op_count;

    logic        in_ready4;
    logic        out_valid4;
    logic [7:0]  out_result4;
    logic [2:0]  out_op4;
    logic        out_err4;
    logic [3:0]  op_count4;

`ifdef BITWISE_PIPE_ALU_REDUCE_EN
    logic red_and, red_or, red_xor;
    logic red_and4, red_or4, red_xor4;
`endif

    bitwise_pipe_alu #(.WIDTH(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_op(out_op), .out_err(out_err), .op_count(op_count)
`ifdef BITWISE_PIPE_ALU_REDUCE_EN
        , .out_red_and(red_and), .out_red_or(red_or), .out_red_xor(red_xor)
`endif
    );

    bitwise_pipe_alu #(.WIDTH(8), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready4), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid4), .out_ready(out_ready), .out_result(out_result4),
        .out_op(out_op4), .out_err(out_err4), .op_count(op_count4)
`ifdef BITWISE_PIPE_ALU_REDUCE_EN
        , .out_red_and(red_and4), .out_red_or(red_or4), .out_red_xor(red_xor4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       err;
    } vec_t;

    int n_total = 0;
    int n_pass  = 0;
    int exp_cnt = 0;
    logic [11:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic       e;
        e = 1'b0;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: r = ~a;
            3'd3: r = ~(a & b);
            3'd4: r = ~(a | b);
            3'd5: r = a ^ b;
            3'd6: r = ~(a ^ b);
            default: begin r = 8'h00; e = 1'b1; end
        endcase
        return {e, op, r};
    endfunction

    // Called mid-cycle, after inputs settle: accounts for the handshakes the next edge performs.
    task automatic score();
        logic [11:0] exp;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_output", 32'd1, 32'd0);
            end else begin
                exp = exp_q.pop_front();
                check("stream_out", {20'd0, out_err, out_op, out_result}, {20'd0, exp});
            end
            exp_cnt++;
        end
        if (in_valid && in_ready) exp_q.push_back(model(in_op, in_a, in_b));
    endtask

    task automatic run_ops(input int n, input int p_in, input int p_out, input int budget,
                           output int cycles);
        int acc;
        acc    = 0;
        cycles = 0;
        while (acc < n && cycles < budget) begin
            in_valid  = (int'($urandom_range(99)) < p_in);
            in_op     = 3'($urandom_range(7));
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
            out_ready = (int'($urandom_range(99)) < p_out);
            #1;
            if (in_valid && in_ready) acc++;
            score();
            tick();
            cycles++;
        end
        if (acc < n) check("run_budget", acc, n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 8 && exp_q.size() > 0; k++) begin
            #1;
            score();
            tick();
        end
        check("drain_empty", exp_q.size(), 32'd0);
        check("run_op_count", {16'd0, op_count}, exp_cnt & 32'hFFFF);
    endtask

    task automatic issue_one(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        in_valid  = 1'b1;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        out_ready = 1'b1;
        #1;
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        in_a     = 8'h00;
        in_b     = 8'h00;
        #1;
        check("lat_not_early", {31'd0, out_valid}, 32'd0);
        tick();
        #1;
        check("lat_valid", {31'd0, out_valid}, 32'd1);
    endtask

    vec_t vecs[8];
    int   cyc;

    initial begin
        vecs[0] = '{3'd0, 8'h03, 8'h05, 8'h01, 1'b0};
        vecs[1] = '{3'd1, 8'h03, 8'h05, 8'h07, 1'b0};
        vecs[2] = '{3'd5, 8'h03, 8'h05, 8'h06, 1'b0};
        vecs[3] = '{3'd6, 8'h03, 8'h05, 8'hF9, 1'b0};
        vecs[4] = '{3'd2, 8'h0F, 8'hAA, 8'hF0, 1'b0};
        vecs[5] = '{3'd3, 8'hFF, 8'h0F, 8'hF0, 1'b0};
        vecs[6] = '{3'd4, 8'h00, 8'h00, 8'hFF, 1'b0};
        vecs[7] = '{3'd7, 8'h5A, 8'hA5, 8'h00, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_op = 3'd0; in_a = 8'h00; in_b = 8'h00;
        tick();
        tick();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_result", {24'd0, out_result}, 32'd0);
        check("rst_out_op", {29'd0, out_op}, 32'd0);
        check("rst_out_err", {31'd0, out_err}, 32'd0);
        check("rst_op_count", {16'd0, op_count}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            issue_one(vecs[i].op, vecs[i].a, vecs[i].b);
            check("vec_result", {24'd0, out_result}, {24'd0, vecs[i].res});
            check("vec_op", {29'd0, out_op}, {29'd0, vecs[i].op});
            check("vec_err", {31'd0, out_err}, {31'd0, vecs[i].err});
            tick();
            exp_cnt++;
            #1;
            check("vec_op_count", {16'd0, op_count}, exp_cnt);
            check("vec_drained", {31'd0, out_valid}, 32'd0);
        end

        // Back-pressure: only two ops fit, the third waits until the output drains.
        tick();
        out_ready = 1'b0; in_valid = 1'b1;
        in_op = 3'd0; in_a = 8'h03; in_b = 8'h05;
        #1; check("bp_ready0", {31'd0, in_ready}, 32'd1);
        tick();
        in_op = 3'd1;
        #1; check("bp_ready1", {31'd0, in_ready}, 32'd1);
        tick();
        in_op = 3'd5;
        #1; check("bp_full_ready", {31'd0, in_ready}, 32'd0);
        check("bp_full_valid", {31'd0, out_valid}, 32'd1);
        check("bp_full_result", {24'd0, out_result}, 32'h01);
        tick();
        tick();
        #1; check("bp_hold_ready", {31'd0, in_ready}, 32'd0);
        check("bp_hold_result", {24'd0, out_result}, 32'h01);
        check("bp_hold_op", {29'd0, out_op}, 32'd0);
        out_ready = 1'b1;
        #1; check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        tick();
        exp_cnt++;
        in_valid = 1'b0;
        #1; check("bp_out1_valid", {31'd0, out_valid}, 32'd1);
        check("bp_out1_result", {24'd0, out_result}, 32'h07);
        tick();
        exp_cnt++;
        #1; check("bp_out2_valid", {31'd0, out_valid}, 32'd1);
        check("bp_out2_result", {24'd0, out_result}, 32'h06);
        tick();
        exp_cnt++;
        #1; check("bp_empty", {31'd0, out_valid}, 32'd0);
        check("bp_op_count", {16'd0, op_count}, exp_cnt);
        tick();

        run_ops(100, 100, 100, 200, cyc);
        check("stream_cycles", cyc, 32'd100);

        run_ops(1000, 70, 60, 20000, cyc);

`ifdef BITWISE_PIPE_ALU_REDUCE_EN
        issue_one(3'd0, 8'hFF, 8'hFF);
        check("red_ff_and", {31'd0, red_and}, 32'd1);
        check("red_ff_or", {31'd0, red_or}, 32'd1);
        check("red_ff_xor", {31'd0, red_xor}, 32'd0);
        tick();
        issue_one(3'd1, 8'h01, 8'h00);
        check("red_01_and", {31'd0, red_and}, 32'd0);
        check("red_01_or", {31'd0, red_or}, 32'd1);
        check("red_01_xor", {31'd0, red_xor}, 32'd1);
        tick();
`endif

        // Reset with both stages occupied drops everything, including the op still in S1.
        in_valid = 1'b1; out_ready = 1'b0;
        in_op = 3'd0; in_a = 8'hFF; in_b = 8'hFF;
        tick();
        in_op = 3'd1;
        tick();
        in_valid = 1'b0;
        #1; check("mid_full", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cnt = 0;
        exp_q.delete();
        #1; check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_count", {16'd0, op_count}, 32'd0);
        check("mid_rst_result", {24'd0, out_result}, 32'd0);
        check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        tick();
        tick();
        #1; check("mid_no_ghost", {31'd0, out_valid}, 32'd0);
        check("cnt4_after_rst", {28'd0, op_count4}, 32'd0);
        tick();

        run_ops(17, 100, 100, 100, cyc);
        check("cnt4_wrap", {28'd0, op_count4}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
